// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Sequenced controller for the 16-bit, 8-register CPU datapath.
//   Each instruction moves through FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
//   The controller can wait in MEM on a slow data memory. HALT and TRAP
//   are terminal states that only reset leaves.
// Ports
//   clk, reset      clock; synchronous active-high reset
//   run             start request, sampled only in IDLE
//   opcode          IR[15:12], latched in DECODE
//   zero            rs1 == rs2 compare result (beq)
//   mem_ready       data memory access completes this cycle (MEM only)
//   ir_we, pc_we    IR load / PC update strobes
//   pc_src          0: PC+1, 1: PC+imm
//   alu_op          ALU function select
//   reg_write       register file write enable
//   mem_read/write  data memory strobes
//   busy            executing (not IDLE/HALT/TRAP)
//   halted/illegal  HALT reached / undefined opcode trapped
//   state           current state encoding (debug)
//   instr_count     retired instructions (wraps)
module multicycle_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic [2:0]       alu_op,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t           r_state;
  logic [3:0]       r_op;
  logic [CNT_W-1:0] r_cnt;

  logic       w_is_alu;
  logic       w_lw;
  logic       w_sw;
  logic       w_beq;
  logic [2:0] w_alu_sel;

  // Class decode of the latched opcode; only meaningful after DECODE.
  assign w_is_alu  = (r_op <= 4'h4);
  assign w_lw      = (r_op == OP_LW);
  assign w_sw      = (r_op == OP_SW);
  assign w_beq     = (r_op == OP_BEQ);
  // Memory ops use the adder for address generation; beq compares via sub.
  assign w_alu_sel = w_is_alu ? r_op[2:0] : (w_beq ? 3'b001 : 3'b000);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= 4'h0;
      r_cnt   <= '0;
    end else begin
      if (pc_we)
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      case (r_state)
        S_IDLE:   if (run) r_state <= S_FETCH;
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          r_op <= opcode;
          if (opcode == OP_HALT)  r_state <= S_HALT;
          else if (opcode[3])     r_state <= S_TRAP;
          else                    r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_is_alu)      r_state <= S_WB;
          else if (w_beq)    r_state <= S_FETCH;
          else               r_state <= S_MEM;
        end
        S_MEM:    if (mem_ready) r_state <= w_lw ? S_WB : S_FETCH;
        S_WB:     r_state <= S_FETCH;
        S_HALT:   r_state <= S_HALT;
        S_TRAP:   r_state <= S_TRAP;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Output decode from state and latched opcode. Two inputs leak through:
  // zero steers pc_src for beq, and mem_ready retires sw in its final MEM cycle.
  always_comb begin
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 1'b0;
    alu_op    = 3'b000;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (r_state)
      S_FETCH: ir_we = 1'b1;
      S_EXEC: begin
        alu_op = w_alu_sel;
        if (w_beq) begin
          pc_we  = 1'b1;
          pc_src = zero;
        end
      end
      S_MEM: begin
        alu_op    = w_alu_sel;
        mem_read  = w_lw;
        mem_write = w_sw;
        pc_we     = w_sw & mem_ready;
      end
      S_WB: begin
        alu_op    = w_alu_sel;
        reg_write = 1'b1;
        pc_we     = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy        = (r_state != S_IDLE) && (r_state != S_HALT) && (r_state != S_TRAP);
  assign halted      = (r_state == S_HALT);
  assign illegal     = (r_state == S_TRAP);
  assign state       = r_state;
  assign instr_count = r_cnt;

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, zero, mem_ready;
  logic [3:0]  opcode;

  logic        ir_we, pc_we, pc_src, reg_write, mem_read, mem_write, busy, halted, illegal;
  logic [2:0]  alu_op, state;
  logic [15:0] instr_count;

  logic        ir_we4, pc_we4, pc_src4, reg_write4, mem_read4, mem_write4, busy4, halted4, illegal4;
  logic [2:0]  alu_op4, state4;
  logic [3:0]  instr_count4;

  multicycle_sequencer u_dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_op(alu_op), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .busy(busy), .halted(halted), .illegal(illegal),
    .state(state), .instr_count(instr_count)
  );

  // Narrow counter copy, fed the same stimulus, to observe wrap-around.
  multicycle_sequencer #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ir_we(ir_we4), .pc_we(pc_we4), .pc_src(pc_src4), .alu_op(alu_op4), .reg_write(reg_write4),
    .mem_read(mem_read4), .mem_write(mem_write4), .busy(busy4), .halted(halted4), .illegal(illegal4),
    .state(state4), .instr_count(instr_count4)
  );

  always #5 clk = ~clk;

  int errors  = 0;
  int checks  = 0;
  int retired = 0;

  // Per-instruction observation, one bit per cycle counted from FETCH.
  typedef struct packed {
    logic [7:0]  cycles;
    logic [2:0]  end_st;
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] rw;
    logic [31:0] mr;
    logic [31:0] mw;
    logic        src;
    logic [7:0]  alu_bad;
    logic [7:0]  notbusy;
  } stats_t;

  function automatic logic [30:0] outs();
    return {ir_we, pc_we, pc_src, alu_op, reg_write, mem_read, mem_write, busy, halted, illegal,
            state, instr_count};
  endfunction

  function automatic logic [2:0] exp_alu(input logic [3:0] op);
    if (op <= 4'h4)  return op[2:0];
    if (op == 4'h7)  return 3'b001;
    return 3'b000;
  endfunction

  // Reference: the instruction's timeline from the ISA-level cycle rules.
  function automatic stats_t model(input logic [3:0] op, input logic z, input int w);
    stats_t s;
    s = '0;
    s.ir = 32'd1;
    if (op >= 4'h8) begin
      s.cycles = 8'd2;
      s.end_st = (op == 4'hF) ? 3'd6 : 3'd7;
      return s;
    end
    s.end_st = 3'd1;
    if (op <= 4'h4) begin
      s.cycles = 8'd4;
      s.pc = 32'd1 << 3;
      s.rw = 32'd1 << 3;
    end else if (op == 4'h7) begin
      s.cycles = 8'd3;
      s.pc = 32'd1 << 2;
      s.src = z;
    end else if (op == 4'h5) begin
      s.cycles = 8'(5 + w);
      s.mr = ((32'd1 << (w + 1)) - 32'd1) << 3;
      s.pc = 32'd1 << (4 + w);
      s.rw = 32'd1 << (4 + w);
    end else begin
      s.cycles = 8'(4 + w);
      s.mw = ((32'd1 << (w + 1)) - 32'd1) << 3;
      s.pc = 32'd1 << (3 + w);
    end
    return s;
  endfunction

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; opcode = 4'h0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    retired = 0;
  endtask

  task automatic start();
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
  endtask

  // Drives one instruction starting in its FETCH cycle; W memory wait cycles.
  task automatic run_instr(input logic [3:0] op, input logic z, input int w,
                           output stats_t s, output logic [23:0] trace);
    int k;
    k = 0; s = '0; trace = '0;
    opcode = op;
    while (1) begin
      zero = (op == 4'h7) ? z : 1'($urandom_range(0, 1));
      if (k < 3) mem_ready = 1'($urandom_range(0, 1));
      else       mem_ready = (k >= 3 + w);
      @(negedge clk);
      trace = {trace[20:0], state};
      if (ir_we)     s.ir[k] = 1'b1;
      if (pc_we)     begin s.pc[k] = 1'b1; s.src = pc_src; end
      if (reg_write) s.rw[k] = 1'b1;
      if (mem_read)  s.mr[k] = 1'b1;
      if (mem_write) s.mw[k] = 1'b1;
      if (alu_op !== ((k >= 2) ? exp_alu(op) : 3'b000)) s.alu_bad++;
      if (busy !== 1'b1) s.notbusy++;
      @(posedge clk); #1;
      k++;
      if (state == 3'd1 || state == 3'd6 || state == 3'd7 || k >= 31) break;
    end
    s.cycles = 8'(k);
    s.end_st = state;
    if (op < 4'h8) retired++;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (outs() !== 31'd0) begin errors++; $display("FAIL reset_outs got %h exp 0", outs()); end
    checks++;
    if ({state4, instr_count4} !== 7'd0) begin errors++; $display("FAIL reset_dut4 got %h exp 0", {state4, instr_count4}); end
    repeat (3) @(posedge clk); #1;
    checks++;
    if (outs() !== 31'd0) begin errors++; $display("FAIL idle_no_run got %h exp 0", outs()); end
  endtask

  task automatic test_add();
    stats_t s; logic [23:0] tr;
    do_reset(); start();
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL run_to_fetch got %0d exp 1", state); end
    run_instr(4'h0, 1'b0, 0, s, tr);
    checks++;
    if (s !== model(4'h0, 1'b0, 0)) begin errors++; $display("FAIL add_stats got %p exp %p", s, model(4'h0, 1'b0, 0)); end
    checks++;
    if ({tr[11:0], state} !== {3'd1, 3'd2, 3'd3, 3'd5, 3'd1}) begin errors++; $display("FAIL add_trace got %h exp 1,2,3,5,1", {tr[11:0], state}); end
    checks++;
    if (instr_count !== 16'd1) begin errors++; $display("FAIL add_count got %0d exp 1", instr_count); end
  endtask

  task automatic test_lw_wait();
    stats_t s; logic [23:0] tr;
    run_instr(4'h5, 1'b0, 3, s, tr);
    checks++;
    if (s !== model(4'h5, 1'b0, 3)) begin errors++; $display("FAIL lw_wait_stats got %p exp %p", s, model(4'h5, 1'b0, 3)); end
    checks++;
    if (instr_count !== 16'(retired)) begin errors++; $display("FAIL lw_count got %0d exp %0d", instr_count, retired); end
  endtask

  task automatic test_beq();
    stats_t s; logic [23:0] tr;
    for (int i = 0; i < 2; i++) begin
      logic z;
      z = (i == 0);
      run_instr(4'h7, z, 0, s, tr);
      checks++;
      if (s !== model(4'h7, z, 0)) begin errors++; $display("FAIL beq_z%0d_stats got %p exp %p", z, s, model(4'h7, z, 0)); end
    end
    checks++;
    if (instr_count !== 16'(retired)) begin errors++; $display("FAIL beq_count got %0d exp %0d", instr_count, retired); end
  endtask

  task automatic test_random();
    stats_t s, e; logic [23:0] tr;
    for (int i = 0; i < 40; i++) begin
      logic [3:0] op; logic z; int w;
      op = 4'($urandom_range(0, 7));
      z  = 1'($urandom_range(0, 1));
      w  = $urandom_range(0, 3);
      e  = model(op, z, w);
      run_instr(op, z, w, s, tr);
      checks++;
      if (s !== e) begin errors++; $display("FAIL rand%0d op%h w%0d got %p exp %p", i, op, w, s, e); end
      checks++;
      if (instr_count !== 16'(retired) || instr_count4 !== 4'(retired))
        begin errors++; $display("FAIL rand%0d_count got %0d/%0d exp %0d", i, instr_count, instr_count4, retired); end
    end
  endtask

  task automatic test_halt();
    stats_t s; logic [23:0] tr; logic [30:0] snap; int bad;
    run_instr(4'hF, 1'b0, 0, s, tr);
    checks++;
    if (s !== model(4'hF, 1'b0, 0)) begin errors++; $display("FAIL halt_stats got %p exp %p", s, model(4'hF, 1'b0, 0)); end
    snap = outs(); bad = 0;
    checks++;
    if ({halted, busy, illegal, state} !== {1'b1, 1'b0, 1'b0, 3'd6} || snap[30:22] !== 9'd0 || instr_count !== 16'(retired))
      begin errors++; $display("FAIL halt_outs got %h retired %0d", snap, retired); end
    run = 1'b1; bad = 0;
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0]; zero = 1'($urandom_range(0, 1)); opcode = 4'($urandom_range(0, 15));
      @(negedge clk);
      if (outs() !== snap) bad++;
    end
    run = 1'b0;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL halt_frozen got %0d changed cycles exp 0", bad); end
  endtask

  task automatic test_trap();
    stats_t s; logic [23:0] tr; int bad;
    do_reset(); start();
    run_instr(4'h1, 1'b0, 0, s, tr);
    run_instr(4'hA, 1'b0, 0, s, tr);
    checks++;
    if (s !== model(4'hA, 1'b0, 0)) begin errors++; $display("FAIL trap_stats got %p exp %p", s, model(4'hA, 1'b0, 0)); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      run = 1'b1; mem_ready = i[0];
      @(negedge clk);
      if ({illegal, halted, busy, state} !== {1'b1, 1'b0, 1'b0, 3'd7} || outs() >> 22 !== 31'd0 || instr_count !== 16'd1) bad++;
    end
    run = 1'b0;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL trap_hold got %0d bad cycles exp 0", bad); end
    do_reset();
    checks++;
    if ({illegal, state} !== 4'd0) begin errors++; $display("FAIL trap_reset got %h exp 0", {illegal, state}); end
  endtask

  task automatic test_reset_mid_mem();
    stats_t s; logic [23:0] tr;
    do_reset(); start();
    run_instr(4'h2, 1'b0, 0, s, tr);
    opcode = 4'h6; mem_ready = 1'b0;
    repeat (3) @(posedge clk); #1;
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({state, mem_write, pc_we} !== {3'd4, 1'b1, 1'b0}) begin errors++; $display("FAIL sw_wait got st%0d mw%0d pc%0d exp st4 mw1 pc0", state, mem_write, pc_we); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b1;
    checks++;
    if ({state, mem_write, instr_count} !== {3'd0, 1'b0, 16'd0}) begin errors++; $display("FAIL mem_reset got st%0d mw%0d cnt%0d exp 0 0 0", state, mem_write, instr_count); end
    checks++;
    if (outs() !== 31'd0) begin errors++; $display("FAIL mem_reset_outs got %h exp 0", outs()); end
  endtask

  task automatic test_wrap();
    stats_t s; logic [23:0] tr;
    do_reset(); start();
    for (int i = 0; i < 15; i++) run_instr(4'($urandom_range(0, 4)), 1'b0, 0, s, tr);
    checks++;
    if (instr_count4 !== 4'd15) begin errors++; $display("FAIL wrap_pre got %0d exp 15", instr_count4); end
    run_instr(4'h3, 1'b0, 0, s, tr);
    checks++;
    if ({instr_count4, instr_count} !== {4'd0, 16'd16}) begin errors++; $display("FAIL wrap got %0d/%0d exp 0/16", instr_count4, instr_count); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_beq();
    test_random();
    test_halt();
    test_trap();
    test_reset_mid_mem();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

endmodule
